multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control unit for the RV32I core: a state machine that sequences fetch, decode, execute, memory and write-back over several cycles instead of decoding one instruction per cycle. It sits between the datapath (PC, IR, regfile, ALU, branch comparator) and the instruction/data memory ports. It drives memory request/ready handshakes and detects illegal instructions and memory timeouts. It also counts retired instructions.

## Interface
- TIMEOUT_CYCLES, 16, maximum wait cycles on one memory request before halting; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- instr_i  in  32  IR contents from the datapath; stable from DECODE until the next IR load.
- br_less_i, br_equal_i  in  1  branch comparator results, valid in EXEC.
- imem_ready_i, dmem_ready_i  in  1  memory completion strobes.
- imem_req_o, dmem_req_o  out  1  memory requests.
- pc_wren_o, ir_wren_o  out  1  PC and IR load strobes.
- br_sel_o  out  1  0: PC+4, 1: ALU result.
- br_unsigned_o  out  1  unsigned compare.
- rd_wren_o  out  1  register-file write enable.
- mem_wren_o  out  1  data-memory write enable.
- op_a_sel_o, op_b_sel_o  out  1  ALU operand A select (0: reg, 1: PC); operand B select (0: reg, 1: imm).
- alu_op_o  out  4  ALU operation, encoded as {instr[30], funct3}; ADD = 0000.
- loadsave_op_o  out  3  funct3 of the load/store.
- wb_sel_o  out  2  write-back source: 00 ALU, 01 memory data, 10 PC+4, 11 imm.
- state_o  out  3  current state.
- illegal_o, timeout_o  out  1  sticky fault flags.
- instret_o  out  CNT_W  retired-instruction count.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Reset state is FETCH.
- FETCH
  - Assert imem_req_o.
  - On imem_ready_i: pulse ir_wren_o and go to DECODE.
- DECODE
  - Classify instr_i. Go to HALT and set illegal_o if any of these holds:
    - instr[1:0] != 11.
    - Opcode is not one of ALU, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
    - Branch funct3 is 010 or 011.
    - Load funct3 is not in {000, 001, 010, 100, 101}.
    - Store funct3 > 010.
  - Otherwise go to EXEC.
- EXEC: drive operand selects and alu_op_o per opcode.
  - ALU: alu_op = {instr[30], funct3}.
  - ALU_I: alu_op = {instr[30], funct3} only when funct3 = 101; otherwise {0, funct3}.
  - LOAD, STORE, JALR: ADD with immediate.
  - BRANCH, JAL, AUIPC: ADD with PC + immediate.
  - BRANCH: pulse pc_wren_o; br_sel_o follows funct3 and the comparator (BEQ: equal; BNE: !equal; BLT/BLTU: less; BGE/BGEU: !less); br_unsigned_o = 1 for BLTU/BGEU; increment instret; go to FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM
  - Assert dmem_req_o. mem_wren_o = 1 for STORE. loadsave_op_o = funct3. ALU controls held as in EXEC.
  - On dmem_ready_i:
    - STORE: pulse pc_wren_o with br_sel_o = 0, increment instret, go to FETCH.
    - LOAD: go to WB.
- WB
  - Assert rd_wren_o and pulse pc_wren_o. br_sel_o = 1 only for JAL/JALR.
  - wb_sel_o: LOAD 01, JAL/JALR 10, LUI 11, else 00. ALU controls held as in EXEC.
  - Increment instret, go to FETCH.
- HALT: all strobes 0. Exit only through rst_i.
- Timeout
  - A wait counter clears on entering FETCH or MEM and increments on each cycle of a request with ready low.
  - When it reaches TIMEOUT_CYCLES: go to HALT and set timeout_o. The request drops.
  - Width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
- instret_o wraps modulo 2^CNT_W.
- Outputs not listed for a state are 0, except loadsave_op_o = funct3 at all times.

## Timing
- State, wait counter, instret and fault flags are registered; all control outputs are combinational from state and instr_i.
- While rst_i is high, every strobe and request output is forced to 0.
- On the first cycle after reset: state FETCH, instret_o = 0, illegal_o = 0, timeout_o = 0, wait counter 0.
- Latency with zero-wait memory (ready high in the first request cycle):
  - BRANCH: 3 cycles.
  - ALU, ALU_I, LUI, AUIPC, JAL, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- A ready strobe arriving in the same cycle the counter reaches the limit counts as success: no halt.
- Ready strobes outside FETCH/MEM are ignored.
- Asserting reset mid-instruction abandons it: instret is not incremented and the PC is not written.

## Structure
- ctrl_pkg holds:
  - OPCODE_* and FUNCT3_* constants.
  - The state_e enum with the encodings above.
  - WB_* and ALU_ADD localparams.
- One sub-module, instr_decoder: purely combinational. Maps instr_i to an opcode class, static controls (alu_op, operand selects, wb_sel) and an illegal flag.
- multicycle_ctrl holds the FSM, wait counter, instret and the branch resolution.

## Test plan
- ADDI x1, x0, 5 (0x00500093), ready always high → states 0,1,2,4,0; rd_wren_o = 1 in WB with wb_sel 00; alu_op 0000 with op_b_sel = 1; instret_o = 1.
- BNE with br_equal_i = 0 → in EXEC: pc_wren_o = 1, br_sel_o = 1, br_unsigned_o = 0; 3-cycle turnaround. Repeat as BGEU with br_less_i = 1 → br_sel_o = 0, br_unsigned_o = 1.
- LW with dmem_ready_i delayed 3 cycles → MEM lasts 4 cycles, dmem_req_o high throughout; WB wb_sel = 01; total 8 cycles.
- TIMEOUT_CYCLES = 4, imem_ready_i held low → HALT after 4 wait cycles; timeout_o = 1; all strobes 0 until rst_i.
- Instruction 0x00000000 → HALT from DECODE, illegal_o = 1, instret_o unchanged; rst_i clears both flags.
- CNT_W = 4: retire 17 instructions → instret_o = 1. Assert rst_i during MEM of a store → no pc_wren_o pulse, state FETCH after reset.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcode, funct3, state and write-back encodings for the multi-cycle control unit
package ctrl_pkg;

  localparam logic [6:0] OPCODE_ALU    = 7'b0110011;
  localparam logic [6:0] OPCODE_ALU_I  = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  localparam logic [2:0] FUNCT3_LB   = 3'b000;
  localparam logic [2:0] FUNCT3_LH   = 3'b001;
  localparam logic [2:0] FUNCT3_LW   = 3'b010;
  localparam logic [2:0] FUNCT3_LBU  = 3'b100;
  localparam logic [2:0] FUNCT3_LHU  = 3'b101;
  localparam logic [2:0] FUNCT3_SW   = 3'b010;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_ALU     = 4'd0,
    CLS_ALU_I   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_ILLEGAL = 4'd9
  } op_class_e;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational RV32I classifier producing static datapath controls and an illegal flag
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  op_class,
  output logic [3:0]  alu_op,
  output logic        op_a_sel,
  output logic        op_b_sel,
  output logic [1:0]  wb_sel,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_op   = ALU_ADD;
    op_a_sel = 1'b0;
    op_b_sel = 1'b0;
    wb_sel   = WB_ALU;
    illegal  = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OPCODE_ALU: begin
          op_class = CLS_ALU;
          alu_op   = {instr[30], funct3};
        end
        OPCODE_ALU_I: begin
          op_class = CLS_ALU_I;
          op_b_sel = 1'b1;
          // instr[30] is an immediate bit except for the SRLI/SRAI shift pair
          alu_op   = (funct3 == FUNCT3_SR) ? {instr[30], funct3} : {1'b0, funct3};
        end
        OPCODE_LOAD: begin
          op_class = CLS_LOAD;
          op_b_sel = 1'b1;
          wb_sel   = WB_MEM;
          if (!(funct3 inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU}))
            illegal = 1'b1;
        end
        OPCODE_STORE: begin
          op_class = CLS_STORE;
          op_b_sel = 1'b1;
          if (funct3 > FUNCT3_SW)
            illegal = 1'b1;
        end
        OPCODE_BRANCH: begin
          op_class = CLS_BRANCH;
          op_a_sel = 1'b1;
          op_b_sel = 1'b1;
          if (funct3 == 3'b010 || funct3 == 3'b011)
            illegal = 1'b1;
        end
        OPCODE_JAL: begin
          op_class = CLS_JAL;
          op_a_sel = 1'b1;
          op_b_sel = 1'b1;
          wb_sel   = WB_PC4;
        end
        OPCODE_JALR: begin
          op_class = CLS_JALR;
          op_b_sel = 1'b1;
          wb_sel   = WB_PC4;
        end
        OPCODE_LUI: begin
          op_class = CLS_LUI;
          wb_sel   = WB_IMM;
        end
        OPCODE_AUIPC: begin
          op_class = CLS_AUIPC;
          op_a_sel = 1'b1;
          op_b_sel = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I sequencer: FSM, memory wait timeout, branch resolution, retire counter
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      instr_i,
  input  logic             br_less_i,
  input  logic             br_equal_i,
  input  logic             imem_ready_i,
  input  logic             dmem_ready_i,
  output logic             imem_req_o,
  output logic             dmem_req_o,
  output logic             pc_wren_o,
  output logic             ir_wren_o,
  output logic             br_sel_o,
  output logic             br_unsigned_o,
  output logic             rd_wren_o,
  output logic             mem_wren_o,
  output logic             op_a_sel_o,
  output logic             op_b_sel_o,
  output logic [3:0]       alu_op_o,
  output logic [2:0]       loadsave_op_o,
  output logic [1:0]       wb_sel_o,
  output logic [2:0]       state_o,
  output logic             illegal_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam int WAIT_W        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int WAIT_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_LAST_INT[WAIT_W-1:0];
  localparam logic TIMEOUT_EN  = (TIMEOUT_CYCLES > 0);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  instret_q;
  logic              illegal_q, timeout_q;

  logic [3:0] dec_class;
  logic [3:0] dec_alu_op;
  logic       dec_op_a, dec_op_b, dec_illegal;
  logic [1:0] dec_wb_sel;
  logic [2:0] funct3;

  logic req_active, ready_cur, wait_expire, br_taken, alu_en;
  logic imem_req_c, dmem_req_c, pc_wren_c, ir_wren_c, rd_wren_c, mem_wren_c;
  logic br_sel_c, br_unsigned_c;
  logic [1:0] wb_sel_c;
  logic retire, set_illegal, set_timeout;

  instr_decoder u_decoder (
    .instr    (instr_i),
    .op_class (dec_class),
    .alu_op   (dec_alu_op),
    .op_a_sel (dec_op_a),
    .op_b_sel (dec_op_b),
    .wb_sel   (dec_wb_sel),
    .illegal  (dec_illegal)
  );

  assign funct3     = instr_i[14:12];
  assign req_active = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign ready_cur  = (state_q == ST_FETCH) ? imem_ready_i : dmem_ready_i;
  // A ready in the last allowed cycle wins over the timeout
  assign wait_expire = TIMEOUT_EN && req_active && !ready_cur && (wait_q == WAIT_LAST);

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      FUNCT3_BEQ:              br_taken = br_equal_i;
      FUNCT3_BNE:              br_taken = !br_equal_i;
      FUNCT3_BLT, FUNCT3_BLTU: br_taken = br_less_i;
      FUNCT3_BGE, FUNCT3_BGEU: br_taken = !br_less_i;
      default:                 br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    imem_req_c    = 1'b0;
    dmem_req_c    = 1'b0;
    pc_wren_c     = 1'b0;
    ir_wren_c     = 1'b0;
    rd_wren_c     = 1'b0;
    mem_wren_c    = 1'b0;
    br_sel_c      = 1'b0;
    br_unsigned_c = 1'b0;
    wb_sel_c      = WB_ALU;
    alu_en        = 1'b0;
    retire        = 1'b0;
    set_illegal   = 1'b0;
    set_timeout   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready_i) begin
          ir_wren_c = 1'b1;
          state_d   = ST_DECODE;
        end else if (wait_expire) begin
          set_timeout = 1'b1;
          state_d     = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          set_illegal = 1'b1;
          state_d     = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_en = 1'b1;
        if (dec_class == CLS_BRANCH) begin
          pc_wren_c     = 1'b1;
          br_sel_c      = br_taken;
          br_unsigned_c = funct3[1];
          retire        = 1'b1;
          state_d       = ST_FETCH;
        end else if (dec_class == CLS_LOAD || dec_class == CLS_STORE) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        alu_en     = 1'b1;
        dmem_req_c = 1'b1;
        mem_wren_c = (dec_class == CLS_STORE);
        if (dmem_ready_i) begin
          if (dec_class == CLS_STORE) begin
            pc_wren_c = 1'b1;
            retire    = 1'b1;
            state_d   = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_expire) begin
          set_timeout = 1'b1;
          state_d     = ST_HALT;
        end
      end
      ST_WB: begin
        alu_en    = 1'b1;
        rd_wren_c = 1'b1;
        pc_wren_c = 1'b1;
        br_sel_c  = (dec_class == CLS_JAL) || (dec_class == CLS_JALR);
        wb_sel_c  = dec_wb_sel;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if (req_active && !ready_cur)
        wait_q <= wait_q + 1'b1;
      if (retire)
        instret_q <= instret_q + 1'b1;
      if (set_illegal)
        illegal_q <= 1'b1;
      if (set_timeout)
        timeout_q <= 1'b1;
    end
  end

  // Strobes are gated by reset so an abandoned instruction never writes PC, IR or memory
  assign imem_req_o    = imem_req_c & ~rst_i;
  assign dmem_req_o    = dmem_req_c & ~rst_i;
  assign pc_wren_o     = pc_wren_c  & ~rst_i;
  assign ir_wren_o     = ir_wren_c  & ~rst_i;
  assign rd_wren_o     = rd_wren_c  & ~rst_i;
  assign mem_wren_o    = mem_wren_c & ~rst_i;
  assign br_sel_o      = br_sel_c;
  assign br_unsigned_o = br_unsigned_c;
  assign wb_sel_o      = wb_sel_c;
  assign alu_op_o      = alu_en ? dec_alu_op : ALU_ADD;
  assign op_a_sel_o    = alu_en & dec_op_a;
  assign op_b_sel_o    = alu_en & dec_op_b;
  assign loadsave_op_o = funct3;
  assign state_o       = state_q;
  assign illegal_o     = illegal_q;
  assign timeout_o     = timeout_q;
  assign instret_o     = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i;
  logic        br_less_i, br_equal_i, imem_ready_i, dmem_ready_i;
  logic        imem_req_o, dmem_req_o, pc_wren_o, ir_wren_o, br_sel_o, br_unsigned_o;
  logic        rd_wren_o, mem_wren_o, op_a_sel_o, op_b_sel_o;
  logic [3:0]  alu_op_o;
  logic [2:0]  loadsave_op_o;
  logic [1:0]  wb_sel_o;
  logic [2:0]  state_o;
  logic        illegal_o, timeout_o;
  logic [3:0]  instret_o;

  multicycle_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i),
    .br_less_i(br_less_i), .br_equal_i(br_equal_i),
    .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i),
    .imem_req_o(imem_req_o), .dmem_req_o(dmem_req_o),
    .pc_wren_o(pc_wren_o), .ir_wren_o(ir_wren_o),
    .br_sel_o(br_sel_o), .br_unsigned_o(br_unsigned_o),
    .rd_wren_o(rd_wren_o), .mem_wren_o(mem_wren_o),
    .op_a_sel_o(op_a_sel_o), .op_b_sel_o(op_b_sel_o),
    .alu_op_o(alu_op_o), .loadsave_op_o(loadsave_op_o), .wb_sel_o(wb_sel_o),
    .state_o(state_o), .illegal_o(illegal_o), .timeout_o(timeout_o),
    .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         cycles;
    logic [2:0] end_state;
    logic       ex_pc, ex_br, ex_bu;
    logic [3:0] ex_alu;
    logic       ex_a, ex_b;
    logic       wb_rd;
    logic [1:0] wb_sel;
    logic       wb_br;
    int         mem_cyc;
    logic       mem_wr;
    logic       illegal, timeout;
    logic [3:0] instret;
  } res_t;

  typedef struct {
    logic [31:0] instr;
    logic        less, equal;
    int          idly, ddly;
    res_t        exp;
  } vec_t;

  int   checks = 0;
  int   passed = 0;
  vec_t tbl[27];
  res_t sb[$];
  res_t obs, expr;
  logic [3:0] model;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic l, input logic e,
                              input int id, input int dd, input int cyc, input logic [2:0] es,
                              input logic xpc, input logic xbr, input logic xbu,
                              input logic [3:0] xalu, input logic xa, input logic xb,
                              input logic wrd, input logic [1:0] wsel, input logic wbr,
                              input int mem, input logic mwr, input logic ill, input logic to);
    vec_t v;
    v.instr = instr; v.less = l; v.equal = e; v.idly = id; v.ddly = dd;
    v.exp.cycles = cyc; v.exp.end_state = es;
    v.exp.ex_pc = xpc; v.exp.ex_br = xbr; v.exp.ex_bu = xbu;
    v.exp.ex_alu = xalu; v.exp.ex_a = xa; v.exp.ex_b = xb;
    v.exp.wb_rd = wrd; v.exp.wb_sel = wsel; v.exp.wb_br = wbr;
    v.exp.mem_cyc = mem; v.exp.mem_wr = mwr;
    v.exp.illegal = ill; v.exp.timeout = to; v.exp.instret = 4'd0;
    return v;
  endfunction

  // Called between a negedge and the following posedge; leaves the bench in the same phase
  task automatic do_reset();
    rst_i = 1'b1; imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic run(input int idly, input int ddly, input logic less, input logic equal,
                     input logic [31:0] instr, output res_t r);
    int fc, mc, n;
    logic left, done;
    fc = 0; mc = 0; n = 0; left = 1'b0; done = 1'b0;
    r.cycles = 0; r.end_state = 3'd0; r.ex_pc = 0; r.ex_br = 0; r.ex_bu = 0; r.ex_alu = 4'd0;
    r.ex_a = 0; r.ex_b = 0; r.wb_rd = 0; r.wb_sel = 2'd0; r.wb_br = 0; r.mem_cyc = 0;
    r.mem_wr = 0; r.illegal = 0; r.timeout = 0; r.instret = 4'd0;
    instr_i = instr; br_less_i = less; br_equal_i = equal;
    for (int c = 0; c < 40; c++) begin
      if (state_o == 3'd5 || (state_o == 3'd0 && left)) begin
        done = 1'b1;
        break;
      end
      imem_ready_i = (state_o == 3'd0) ? (fc >= idly) : 1'b1;
      dmem_ready_i = (state_o == 3'd3) ? (mc >= ddly) : 1'b1;
      #1;
      n++;
      if (state_o == 3'd0) fc++;
      else left = 1'b1;
      if (state_o == 3'd2) begin
        r.ex_pc = pc_wren_o; r.ex_br = br_sel_o; r.ex_bu = br_unsigned_o;
        r.ex_alu = alu_op_o; r.ex_a = op_a_sel_o; r.ex_b = op_b_sel_o;
      end
      if (state_o == 3'd3) begin
        mc++;
        if (dmem_req_o) r.mem_cyc++;
        if (mem_wren_o) r.mem_wr = 1'b1;
      end
      if (state_o == 3'd4) begin
        r.wb_rd = rd_wren_o; r.wb_sel = wb_sel_o; r.wb_br = br_sel_o;
      end
      @(negedge clk_i);
    end
    imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
    chk("run_budget", done, 1'b1);
    r.cycles = n; r.end_state = state_o;
    r.illegal = illegal_o; r.timeout = timeout_o; r.instret = instret_o;
  endtask

  task automatic cmp(input int i, input res_t a, input res_t e);
    chk($sformatf("v%0d cycles", i), a.cycles, e.cycles);
    chk($sformatf("v%0d end_state", i), a.end_state, e.end_state);
    chk($sformatf("v%0d exec_ctl", i), {a.ex_pc, a.ex_br, a.ex_bu, a.ex_a, a.ex_b, a.ex_alu},
        {e.ex_pc, e.ex_br, e.ex_bu, e.ex_a, e.ex_b, e.ex_alu});
    chk($sformatf("v%0d wb_ctl", i), {a.wb_rd, a.wb_br, a.wb_sel}, {e.wb_rd, e.wb_br, e.wb_sel});
    chk($sformatf("v%0d mem", i), {a.mem_wr, a.mem_cyc[7:0]}, {e.mem_wr, e.mem_cyc[7:0]});
    chk($sformatf("v%0d flags", i), {a.illegal, a.timeout}, {e.illegal, e.timeout});
    chk($sformatf("v%0d instret", i), a.instret, e.instret);
  endtask

  initial begin
    //            instr        l  e  id dd cyc st pc br bu alu   a  b  rd wb    wbr mem mw il to
    tbl[0]  = mk(32'h00500093, 0, 0, 0, 0, 4, 0, 0, 0, 0, 4'h0, 0, 1, 1, 2'd0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(32'h00209463, 0, 0, 0, 0, 3, 0, 1, 1, 0, 4'h0, 1, 1, 0, 2'd0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(32'h0020F463, 1, 0, 0, 0, 3, 0, 1, 0, 1, 4'h0, 1, 1, 0, 2'd0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(32'h0000A183, 0, 0, 0, 3, 8, 0, 0, 0, 0, 4'h0, 0, 1, 1, 2'd1, 0, 4, 0, 0, 0);
    tbl[4]  = mk(32'h0020A223, 0, 0, 0, 0, 4, 0, 0, 0, 0, 4'h0, 0, 1, 0, 2'd0, 0, 1, 1, 0, 0);
    tbl[5]  = mk(32'h402081B3, 0, 0, 0, 0, 4, 0, 0, 0, 0, 4'h8, 0, 0, 1, 2'd0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(32'h4030D093, 0, 0, 0, 0, 4, 0, 0, 0, 0, 4'hD, 0, 1, 1, 2'd0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(32'h40000093, 0, 0, 0, 0, 4, 0, 0, 0, 0, 4'h0, 0, 1, 1, 2'd0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(32'h008000EF, 0, 0, 0, 0, 4, 0, 0, 0, 0, 4'h0, 1, 1, 1, 2'd2, 1, 0, 0, 0, 0);
    tbl[9]  = mk(32'h000100E7, 0, 0, 0, 0, 4, 0, 0, 0, 0, 4'h0, 0, 1, 1, 2'd2, 1, 0, 0, 0, 0);
    tbl[10] = mk(32'h123452B7, 0, 0, 0, 0, 4, 0, 0, 0, 0, 4'h0, 0, 0, 1, 2'd3, 0, 0, 0, 0, 0);
    tbl[11] = mk(32'h00001297, 0, 0, 0, 0, 4, 0, 0, 0, 0, 4'h0, 1, 1, 1, 2'd0, 0, 0, 0, 0, 0);
    tbl[12] = mk(32'h0000A183, 0, 0, 2, 0, 7, 0, 0, 0, 0, 4'h0, 0, 1, 1, 2'd1, 0, 1, 0, 0, 0);
    tbl[13] = mk(32'h00208463, 0, 1, 0, 0, 3, 0, 1, 1, 0, 4'h0, 1, 1, 0, 2'd0, 0, 0, 0, 0, 0);
    tbl[14] = mk(32'h0020C463, 0, 0, 0, 0, 3, 0, 1, 0, 0, 4'h0, 1, 1, 0, 2'd0, 0, 0, 0, 0, 0);
    tbl[15] = mk(32'h0020A223, 0, 0, 0, 2, 6, 0, 0, 0, 0, 4'h0, 0, 1, 0, 2'd0, 0, 3, 1, 0, 0);
    tbl[16] = mk(32'h0000D183, 0, 0, 0, 0, 5, 0, 0, 0, 0, 4'h0, 0, 1, 1, 2'd1, 0, 1, 0, 0, 0);
    tbl[17] = mk(32'h0020E463, 1, 0, 0, 0, 3, 0, 1, 1, 1, 4'h0, 1, 1, 0, 2'd0, 0, 0, 0, 0, 0);
    tbl[18] = mk(32'h00000000, 0, 0, 0, 0, 2, 5, 0, 0, 0, 4'h0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0);
    tbl[19] = mk(32'h00500091, 0, 0, 0, 0, 2, 5, 0, 0, 0, 4'h0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0);
    tbl[20] = mk(32'h0000007F, 0, 0, 0, 0, 2, 5, 0, 0, 0, 4'h0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0);
    tbl[21] = mk(32'h0020A463, 0, 0, 0, 0, 2, 5, 0, 0, 0, 4'h0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0);
    tbl[22] = mk(32'h0000B183, 0, 0, 0, 0, 2, 5, 0, 0, 0, 4'h0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0);
    tbl[23] = mk(32'h0000E183, 0, 0, 0, 0, 2, 5, 0, 0, 0, 4'h0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0);
    tbl[24] = mk(32'h0020B223, 0, 0, 0, 0, 2, 5, 0, 0, 0, 4'h0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0);
    tbl[25] = mk(32'h00500093, 0, 0, 99, 0, 4, 5, 0, 0, 0, 4'h0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1);
    tbl[26] = mk(32'h0000A183, 0, 0, 0, 99, 7, 5, 0, 0, 0, 4'h0, 0, 1, 0, 2'd0, 0, 4, 0, 0, 1);

    rst_i = 1'b1; instr_i = 32'h00500093; br_less_i = 1'b0; br_equal_i = 1'b0;
    imem_ready_i = 1'b1; dmem_ready_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rst_strobes", {imem_req_o, dmem_req_o, pc_wren_o, ir_wren_o, rd_wren_o, mem_wren_o}, 6'd0);
    @(negedge clk_i);
    rst_i = 1'b0; imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
    #1;
    chk("post_rst_state", state_o, 3'd0);
    chk("post_rst_counters", {illegal_o, timeout_o, instret_o}, 6'd0);
    chk("post_rst_imem_req", imem_req_o, 1'b1);

    model = 4'd0;
    for (int i = 0; i < 27; i++) begin
      if (tbl[i].exp.end_state != 3'd5) model = model + 4'd1;
      tbl[i].exp.instret = model;
      sb.push_back(tbl[i].exp);
      run(tbl[i].idly, tbl[i].ddly, tbl[i].less, tbl[i].equal, tbl[i].instr, obs);
      expr = sb.pop_front();
      cmp(i, obs, expr);
      if (tbl[i].exp.end_state == 3'd5) begin
        do_reset();
        model = 4'd0;
      end
    end

    // Illegal instruction leaves instret alone; reset clears the sticky flag
    do_reset();
    run(0, 0, 1'b0, 1'b0, 32'h00500093, obs);
    run(0, 0, 1'b0, 1'b0, 32'h00000000, obs);
    chk("illegal_instret_held", obs.instret, 4'd1);
    chk("illegal_flag", obs.illegal, 1'b1);
    do_reset();
    #1;
    chk("illegal_cleared", {illegal_o, state_o}, 4'd0);

    // Fetch timeout: HALT is inert even with both ready strobes high
    run(99, 0, 1'b0, 1'b0, 32'h00500093, obs);
    for (int c = 0; c < 3; c++) begin
      imem_ready_i = 1'b1; dmem_ready_i = 1'b1;
      #1;
      chk("halt_strobes", {imem_req_o, dmem_req_o, pc_wren_o, ir_wren_o, rd_wren_o, mem_wren_o}, 6'd0);
      chk("halt_state", {state_o, timeout_o}, {3'd5, 1'b1});
      @(negedge clk_i);
    end
    do_reset();
    #1;
    chk("timeout_cleared", {timeout_o, state_o}, 4'd0);

    // 17 retirements wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) run(0, 0, 1'b0, 1'b0, 32'h00500093, obs);
    chk("wrap_instret", instret_o, 4'd1);

    // Reset in the middle of a store's MEM phase must not write the PC
    begin
      logic found;
      found = 1'b0;
      instr_i = 32'h0020A223;
      for (int c = 0; c < 20; c++) begin
        imem_ready_i = (state_o == 3'd0);
        dmem_ready_i = 1'b0;
        #1;
        if (state_o == 3'd3) begin
          found = 1'b1;
          break;
        end
        @(negedge clk_i);
      end
      chk("store_reached_mem", found, 1'b1);
      @(negedge clk_i);
      rst_i = 1'b1; imem_ready_i = 1'b0; dmem_ready_i = 1'b1;
      #1;
      chk("rst_mem_pc_wren", pc_wren_o, 1'b0);
      chk("rst_mem_dmem_req", {dmem_req_o, mem_wren_o}, 2'd0);
      @(negedge clk_i);
      rst_i = 1'b0; dmem_ready_i = 1'b0;
      #1;
      chk("rst_mem_state", state_o, 3'd0);
      chk("rst_mem_instret", instret_o, 4'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
